// File: rtl/fd_pipe_ce.sv
`default_nettype none
// ============================================================================
//  Module   : fd_pipe_ce
//  Purpose  : WIDTH-bit delay pipeline of DEPTH enabled stages with per-stage
//             valid bits, synchronous flush, occupancy count and a stage tap.
//  Revision : 1.0
// ============================================================================

module fd_pipe_ce #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int SELW  = 2,
  parameter int CNTW  = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic             CLR,
  input  logic [WIDTH-1:0] D,
  input  logic             DV,
  output logic [WIDTH-1:0] Q,
  output logic             QV,
  input  logic [SELW-1:0]  TAP_SEL,
  output logic [WIDTH-1:0] TAP_Q,
  output logic             TAP_V,
  output logic [CNTW-1:0]  CNT,
  output logic             EMPTY,
  output logic             FULL
);

  logic [WIDTH-1:0] r_stage [DEPTH];
  logic [WIDTH-1:0] w_next  [DEPTH];
  logic [DEPTH-1:0] r_v;
  logic [DEPTH-1:0] w_vnext;
  logic [CNTW-1:0]  r_cnt;
  logic [WIDTH-1:0] w_tap_q;
  logic             w_tap_v;

  // Shift-in source for each stage: D/DV feed stage 0, every other stage
  // takes its predecessor.
  assign w_next[0]  = D;
  assign w_vnext[0] = DV;

  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_link
      assign w_next[gi]  = r_stage[gi-1];
      assign w_vnext[gi] = r_v[gi-1];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
      r_v   <= '0;
      r_cnt <= '0;
    end else if (CE) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= w_next[i];
      end
      r_v   <= w_vnext;
      // Incoming valid adds, outgoing valid leaves; full plus DV stays full.
      r_cnt <= r_cnt + CNTW'(DV) - CNTW'(r_v[DEPTH-1]);
    end
  end

  // Tap decode by equality so out-of-range selects fall through to zero.
  always_comb begin
    w_tap_q = '0;
    w_tap_v = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (TAP_SEL == SELW'(i)) begin
        w_tap_q = r_stage[i];
        w_tap_v = r_v[i];
      end
    end
  end

  assign Q     = r_stage[DEPTH-1];
  assign QV    = r_v[DEPTH-1];
  assign TAP_Q = w_tap_q;
  assign TAP_V = w_tap_v;
  assign CNT   = r_cnt;
  assign EMPTY = (r_cnt == '0);
  assign FULL  = (r_cnt == CNTW'(DEPTH));

endmodule

`default_nettype wire

// File: tb/tb_fd_pipe_ce.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fd_pipe_ce
//  Purpose  : Randomised and directed bench for fd_pipe_ce (DEPTH 4 and 3)
//             against a queue-based model of the pipe contents.
//  Revision : 1.0
// ============================================================================

module tb_fd_pipe_ce;

  logic        CLK = 1'b0;
  logic        RST, CE, CLR, DV;
  logic [31:0] D;
  logic [1:0]  TAP_SEL, TAP_SEL3;

  logic [31:0] Q, TAP_Q, Q3, TAP_Q3;
  logic        QV, TAP_V, EMPTY, FULL, QV3, TAP_V3, EMPTY3, FULL3;
  logic [2:0]  CNT;
  logic [1:0]  CNT3;

  int checks   = 0;
  int failures = 0;

  // Model: index 0 is the newest stage; entry bit 32 is the valid flag.
  logic [32:0] m4[$];
  logic [32:0] m3[$];

  always #5 CLK = ~CLK;

  fd_pipe_ce #(.WIDTH(32), .DEPTH(4), .SELW(2), .CNTW(3)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .CLR(CLR), .D(D), .DV(DV),
    .Q(Q), .QV(QV), .TAP_SEL(TAP_SEL), .TAP_Q(TAP_Q), .TAP_V(TAP_V),
    .CNT(CNT), .EMPTY(EMPTY), .FULL(FULL)
  );

  fd_pipe_ce #(.WIDTH(32), .DEPTH(3), .SELW(2), .CNTW(2)) dut3 (
    .CLK(CLK), .RST(RST), .CE(CE), .CLR(CLR), .D(D), .DV(DV),
    .Q(Q3), .QV(QV3), .TAP_SEL(TAP_SEL3), .TAP_Q(TAP_Q3), .TAP_V(TAP_V3),
    .CNT(CNT3), .EMPTY(EMPTY3), .FULL(FULL3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int nvalid(input logic [32:0] q[$]);
    int n = 0;
    foreach (q[i]) n += int'(q[i][32]);
    return n;
  endfunction

  task automatic check_all();
    int n4 = nvalid(m4);
    int n3 = nvalid(m3);
    chk("q4",     Q,            m4[3][31:0]);
    chk("qv4",    32'(QV),      32'(m4[3][32]));
    chk("cnt4",   32'(CNT),     n4);
    chk("empty4", 32'(EMPTY),   32'(n4 == 0));
    chk("full4",  32'(FULL),    32'(n4 == 4));
    chk("tapq4",  TAP_Q,        m4[TAP_SEL][31:0]);
    chk("tapv4",  32'(TAP_V),   32'(m4[TAP_SEL][32]));
    chk("q3",     Q3,           m3[2][31:0]);
    chk("qv3",    32'(QV3),     32'(m3[2][32]));
    chk("cnt3",   32'(CNT3),    n3);
    chk("full3",  32'(FULL3),   32'(n3 == 3));
    chk("empty3", 32'(EMPTY3),  32'(n3 == 0));
    if (TAP_SEL3 == 2'd3) begin
      chk("tapq3_oor", TAP_Q3,      32'h0);
      chk("tapv3_oor", 32'(TAP_V3), 32'h0);
    end else begin
      chk("tapq3", TAP_Q3,      m3[TAP_SEL3][31:0]);
      chk("tapv3", 32'(TAP_V3), 32'(m3[TAP_SEL3][32]));
    end
  endtask

  task automatic step(input logic rst, input logic clr, input logic ce,
                      input logic dv, input logic [31:0] d);
    RST = rst; CLR = clr; CE = ce; DV = dv; D = d;
    TAP_SEL  = 2'($urandom_range(0, 3));
    TAP_SEL3 = 2'($urandom_range(0, 3));
    @(posedge CLK);
    #1;
    if (rst || clr) begin
      m4 = {}; m3 = {};
      repeat (4) m4.push_back(33'h0);
      repeat (3) m3.push_back(33'h0);
    end else if (ce) begin
      m4.push_front({dv, d}); void'(m4.pop_back());
      m3.push_front({dv, d}); void'(m3.pop_back());
    end
    check_all();
  endtask

  initial begin
    RST = 1'b1; CLR = 1'b0; CE = 1'b0; DV = 1'b0; D = '0;
    TAP_SEL = '0; TAP_SEL3 = '0;

    // Reset and fill
    step(1, 0, 1, 1, 32'hFFFF_FFFF);
    step(1, 0, 0, 0, 32'h0);
    chk("rst_q", Q, 32'h0);
    chk("rst_qv", 32'(QV), 32'h0);
    chk("rst_cnt", 32'(CNT), 32'h0);
    chk("rst_empty", 32'(EMPTY), 32'h1);
    step(0, 0, 1, 1, 32'h11); chk("fill_cnt1", 32'(CNT), 32'd1);
    step(0, 0, 1, 1, 32'h22); chk("fill_cnt2", 32'(CNT), 32'd2);
    step(0, 0, 1, 1, 32'h33); chk("fill_cnt3", 32'(CNT), 32'd3);
    step(0, 0, 1, 1, 32'h44); chk("fill_cnt4", 32'(CNT), 32'd4);
    chk("fill_q", Q, 32'h11);
    chk("fill_qv", 32'(QV), 32'h1);
    chk("fill_full", 32'(FULL), 32'h1);

    // Tap sweep on the full pipe, without clocking
    for (int s = 0; s < 4; s++) begin
      TAP_SEL = 2'(s);
      TAP_SEL3 = 2'd3;
      #1;
      chk("tap_sweep_q", TAP_Q, 32'h44 - 32'(s) * 32'h11);
      chk("tap_sweep_v", 32'(TAP_V), 32'h1);
      chk("tap3_oor_q", TAP_Q3, 32'h0);
      chk("tap3_oor_v", 32'(TAP_V3), 32'h0);
    end

    // Stall
    repeat (3) begin
      step(0, 0, 0, 1, 32'hDEAD);
      chk("stall_q", Q, 32'h11);
      chk("stall_cnt", 32'(CNT), 32'd4);
    end
    step(0, 0, 1, 1, 32'h55);
    chk("unstall_q", Q, 32'h22);
    chk("unstall_cnt", 32'(CNT), 32'd4);

    // Flush priority over CE with data presented
    step(0, 1, 1, 1, 32'h99);
    chk("clr_cnt", 32'(CNT), 32'h0);
    chk("clr_qv", 32'(QV), 32'h0);
    chk("clr_empty", 32'(EMPTY), 32'h1);

    // Bubbles
    step(0, 0, 1, 1, 32'hA0);
    step(0, 0, 1, 0, 32'hA1);
    step(0, 0, 1, 1, 32'hA2);
    chk("bub_cnt_peak", 32'(CNT), 32'd2);
    step(0, 0, 1, 0, 32'hA3);
    chk("bub_q0", Q, 32'hA0);
    chk("bub_qv0", 32'(QV), 32'h1);
    step(0, 0, 1, 0, 32'h0);
    chk("bub_qv1", 32'(QV), 32'h0);
    step(0, 0, 1, 0, 32'h0);
    chk("bub_q2", Q, 32'hA2);
    chk("bub_qv2", 32'(QV), 32'h1);
    step(0, 0, 1, 0, 32'h0);
    chk("bub_qv3", 32'(QV), 32'h0);

    // Reset mid-stream
    step(0, 0, 1, 1, 32'h1);
    step(0, 0, 1, 1, 32'h2);
    step(1, 0, 1, 1, 32'h3);
    chk("rst_mid_cnt", 32'(CNT), 32'h0);
    chk("rst_mid_empty", 32'(EMPTY), 32'h1);

    // Random run
    for (int n = 0; n < 2000; n++) begin
      step(($urandom_range(0, 499) == 0),
           ($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 70),
           1'($urandom),
           $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fd_pipe_ce.md
Name: fd_pipe_ce

Overview:
- Parametrised multi-stage register pipeline with clock enable; the generalised successor of the single 32-bit enabled data register.
- Delays a WIDTH-bit word by DEPTH enabled clocks and carries a valid bit alongside each stage.
- Provides a synchronous flush, a stage-occupancy count, full/empty flags and a selectable tap.
- Sits between OCR datapath stages that must be delay-matched and stalled together.

Parameters:
- WIDTH, 32, data word width in bits (>=1).
- DEPTH, 4, number of register stages and latency in enabled clocks (>=1).
- SELW, 2, width of TAP_SEL; must satisfy 2^SELW >= DEPTH.
- CNTW, 3, width of CNT; must satisfy 2^CNTW > DEPTH.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  reset, synchronous, active-high.
- CE  input  1  advance enable; when low, all stages hold.
- CLR  input  1  synchronous flush of all stages.
- D  input  WIDTH  data in.
- DV  input  1  valid qualifier for D.
- Q  output  WIDTH  last stage data (stage DEPTH-1), registered.
- QV  output  1  last stage valid, registered.
- TAP_SEL  input  SELW  stage index for the tap.
- TAP_Q  output  WIDTH  data of stage TAP_SEL (combinational mux of registers).
- TAP_V  output  1  valid of stage TAP_SEL.
- CNT  output  CNTW  number of stages holding valid data, 0..DEPTH.
- EMPTY  output  1  CNT==0.
- FULL  output  1  CNT==DEPTH.

Behaviour:
- Storage: stage[0..DEPTH-1] of WIDTH bits, plus v[0..DEPTH-1].
- Priority per rising edge: RST > CLR > CE > hold.
- RST=1: all stage data=0, all v=0, CNT=0. Resulting outputs: Q=0, QV=0, TAP_Q=0, TAP_V=0, EMPTY=1, FULL=0. RST overrides CE/CLR/D in the same cycle. Reset mid-stream discards all in-flight words.
- CLR=1 (RST=0): identical effect to RST, regardless of CE. D/DV presented in that cycle are not captured.
- CE=1 (RST=0, CLR=0):
  - stage[0]<=D, v[0]<=DV.
  - stage[i]<=stage[i-1], v[i]<=v[i-1] for i=1..DEPTH-1.
  - Data is shifted even when DV=0; invalid words still move through.
- CE=0: every stage, v bit and CNT holds. D/DV are ignored.
- Latency: a word captured on enabled edge k appears on Q/QV after the DEPTH-th enabled edge counting k as the first. Disabled cycles stretch latency but never drop or duplicate words.
- CNT (registered, maintained incrementally):
  - On an enabled edge: CNT <= CNT + DV - v[DEPTH-1] (pre-edge value).
  - Otherwise holds.
  - Never wraps. When full, an enabled edge with DV=1 keeps CNT=DEPTH, because the outgoing word leaves.
  - CNT must equal popcount(v) at all times.
- EMPTY and FULL are decoded from CNT.
- DEPTH=1: Q/QV are a single enabled register with synchronous reset and flush; CNT width is still CNTW.
- Tap:
  - TAP_Q=stage[TAP_SEL], TAP_V=v[TAP_SEL], with no added latency.
  - TAP_SEL>=DEPTH returns TAP_Q=0, TAP_V=0.
  - TAP_SEL=DEPTH-1 mirrors Q/QV.
- No X propagation: all registers are defined after the first RST edge. Outputs before the first reset are unspecified.

Test Plan (WIDTH=32, DEPTH=4):
1. Reset and fill:
   - Stimulus: RST high 2 clocks. Then CE=1, DV=1, D=0x11,0x22,0x33,0x44 on consecutive clocks.
   - Required: after reset, Q=0, QV=0, CNT=0, EMPTY=1. Q=0x11 with QV=1 after the 4th edge. CNT steps 1,2,3,4. FULL=1 after the 4th edge.
2. Stall:
   - Stimulus: with the pipe full, CE=0 for 3 clocks while D=0xDEAD, DV=1. Then CE=1 with D=0x55.
   - Required: Q stays 0x11 and CNT stays 4 during the stall. Next edge gives Q=0x22, CNT=4, and 0xDEAD never appears.
3. Bubbles:
   - Stimulus: CE=1, DV pattern 1,0,1,0 with D=0xA0..0xA3 into an empty pipe.
   - Required: QV sequence 1,0,1,0 starting at edge 4 with Q=0xA0 then 0xA2 on valid cycles. CNT peaks at 2.
4. Flush priority:
   - Stimulus: full pipe, CLR=1, CE=1, DV=1, D=0x99 for one clock.
   - Required: CNT=0, QV=0, Q=0, EMPTY=1. 0x99 is not captured.
   - Stimulus: RST=1 and CLR=0 mid-stream.
   - Required: same result as the flush.
5. Tap:
   - Stimulus: after filling 0x11..0x44, sweep TAP_SEL=0..3.
   - Required: TAP_Q=0x44,0x33,0x22,0x11 with TAP_V=1 in the same cycle.
   - Stimulus: repeat with DEPTH=3 and TAP_SEL=3.
   - Required: TAP_Q=0, TAP_V=0.
6. Count invariant:
   - Stimulus: 2000 cycles of random CE/DV/CLR (CLR at 2%).
   - Required: CNT==popcount(v) every cycle. Q sequence matches a reference queue model gated by CE.
